seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
//  Holds one 4-bit hex value per digit and feeds each value in turn to the single shared
//  seven_segment decoder via dec_nibble. Drives the matching active-low anode.
//  Inserts a blanking gap between digits to suppress ghosting.
//  Double-buffered: host writes a shadow bank, which is committed to the displayed bank
//  only at a frame boundary, so the display never tears.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, legal 2..8
//  REFRESH_DIV   50000  clk cycles per digit slot (ON + BLANK), legal >= 2
//  BLANK_CYCLES  500    cycles per slot with all anodes off, legal 1..REFRESH_DIV-1
//  IDX_W         $clog2(NUM_DIGITS)  derived, width of digit index
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rst_n         in   1           asynchronous active-low reset
//  wr_en         in   1           write wr_data into shadow[wr_idx] this cycle
//  wr_idx        in   IDX_W       shadow digit index; values >= NUM_DIGITS are ignored
//  wr_data       in   4           hex value to store
//  commit_req    in   1           one-cycle pulse: copy shadow->active at next frame end
//  blank_mask    in   NUM_DIGITS  1 = keep that digit's anode off; sampled every cycle
//  dec_nibble    out  4           value to the seven_segment decoder input
//  an_n          out  NUM_DIGITS  active-low anode enables, at most one bit low
//  commit_pend   out  1           commit requested, not yet applied
//  commit_done   out  1           one-cycle pulse in the cycle the copy takes effect
//  frame_tick    out  1           one-cycle pulse at the end of every full scan frame
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, idx=0, shadow and active banks all 4'h0, an_n all 1s,
//   dec_nibble=4'h0, commit_pend=0, commit_done=0, frame_tick=0. Mid-frame reset aborts
//   the scan and discards any pending commit. Scan restarts at digit 0 on release.
//  Slot counter cnt: 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and idx advances.
//   idx wraps from NUM_DIGITS-1 to 0.
//  Slot phases:
//   - ON: cnt < REFRESH_DIV-BLANK_CYCLES.
//   - BLANK: the remaining BLANK_CYCLES cycles.
//  All outputs are registered, with 1 cycle latency from the (cnt,idx) state.
//   - an_n[i] <= 0 iff i==idx, phase==ON and blank_mask[i]==0; all other bits are 1.
//   - dec_nibble <= active[idx] while phase==ON. It holds its last value during BLANK.
//  Frame end: cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1. frame_tick <= 1 for that one
//   cycle.
//  Writes: wr_en with wr_idx < NUM_DIGITS updates shadow[wr_idx] on the next edge.
//   Writes never touch active directly. No backpressure: a write is always accepted.
//  Commit: commit_req sets commit_pend. At frame end with commit_pend set (or commit_req
//   asserted that same cycle): active <= shadow, commit_pend <= 0, commit_done <= 1 for
//   one cycle. A second commit_req while pending has no extra effect.
//  Write and copy in the same cycle: the copy takes the pre-write shadow. The new value
//   stays in shadow until the next commit.
//  commit_req in the same cycle as a commit copy: that request is consumed by the copy.
//  blank_mask change: takes effect on the next an_n update. Slot timing is unchanged.
//  The scan timing never stalls.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
//  - Reset, then release with no writes -> an_n cycles 1110 (6 clk), 1111 (2), 1101 (6)...
//    dec_nibble=0. frame_tick pulses every 32 clk.
//  - Write shadow=[1,2,3,4], pulse commit_req mid-frame -> commit_pend=1 until frame end.
//    Then commit_done pulse. The next frame shows 1,2,3,4 on digits 0..3.
//  - Write shadow[2]=A without commit -> display is unchanged across 3 frames. After a
//    commit, digit 2 shows A.
//  - Write shadow[0]=F and commit_req in the exact frame-end cycle -> the copy happens.
//    active[0] holds the old value. A later commit shows F.
//  - blank_mask=0100 -> an_n[2] stays 1 for a full frame. The other digits scan normally.
//  - Assert rst_n=0 mid-slot with a commit pending -> outputs return to reset values
//    immediately. commit_pend=0. Both banks are 0.
//  - wr_idx=5 (when IDX_W allows) -> ignored, and no bank changes.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A double-buffered digit bank is committed only at frame boundaries; each slot ends with a blanking gap.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned IDX_W        = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_data,
   input  logic                  commit_req,
   input  logic [NUM_DIGITS-1:0] blank_mask,
   output logic [3:0]            dec_nibble,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic                  commit_pend,
   output logic                  commit_done,
   output logic                  frame_tick
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] ON_END   = CNT_W'(REFRESH_DIV - BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [3:0]            shadow [NUM_DIGITS];
   logic [3:0]            active [NUM_DIGITS];
   logic                  phase_on;
   logic                  slot_end;
   logic                  frame_end;
   logic                  wr_ok;
   logic [NUM_DIGITS-1:0] an_next;

   assign phase_on  = (cnt < ON_END);
   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // Range check only exists when the index field can encode non-existent digits.
   if ((1 << IDX_W) != NUM_DIGITS) begin : g_idx_chk
      assign wr_ok = wr_en && (wr_idx < IDX_W'(NUM_DIGITS));
   end else begin : g_idx_full
      assign wr_ok = wr_en;
   end

   always_comb begin
      an_next = '1;
      if (phase_on && !blank_mask[idx]) an_next[idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         an_n        <= '1;
         dec_nibble  <= '0;
         commit_pend <= 1'b0;
         commit_done <= 1'b0;
         frame_tick  <= 1'b0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         an_n       <= an_next;
         frame_tick <= frame_end;
         if (phase_on) dec_nibble <= active[idx];

         if (wr_ok) shadow[wr_idx] <= wr_data;

         // The copy reads shadow before any same-cycle write lands; a same-cycle request is absorbed.
         if (frame_end && (commit_pend || commit_req)) begin
            active      <= shadow;
            commit_pend <= 1'b0;
            commit_done <= 1'b1;
         end else begin
            commit_done <= 1'b0;
            if (commit_req) commit_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seven_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [3:0] wr_data;
   logic       commit_req;
   logic [3:0] blank_mask;
   logic [3:0] dec_nibble;
   logic [3:0] an_n;
   logic       commit_pend;
   logic       commit_done;
   logic       frame_tick;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .commit_req (commit_req),
      .blank_mask (blank_mask),
      .dec_nibble (dec_nibble),
      .an_n       (an_n),
      .commit_pend(commit_pend),
      .commit_done(commit_done),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  mask;
      logic [3:0]  an;
      logic [3:0]  dec;
      logic        ft;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto_cyc(input int unsigned n);
      while (cyc < n) tick();
   endtask

   task automatic wr(input logic [1:0] i, input logic [3:0] d);
      wr_en = 1'b1; wr_idx = i; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_an_n", 32'(an_n), 32'hF);
      chk("rst_dec", 32'(dec_nibble), 32'h0);
      chk("rst_pend", 32'(commit_pend), 32'h0);
      chk("rst_done", 32'(commit_done), 32'h0);
      chk("rst_ftick", 32'(frame_tick), 32'h0);
   endtask

   initial begin
      // cycle k = outputs after the k-th rising edge since reset release
      vecs[0]  = '{1,  4'b0000, 4'b1110, 4'h0, 1'b0};
      vecs[1]  = '{6,  4'b0000, 4'b1110, 4'h0, 1'b0};
      vecs[2]  = '{7,  4'b0000, 4'b1111, 4'h0, 1'b0};
      vecs[3]  = '{8,  4'b0000, 4'b1111, 4'h0, 1'b0};
      vecs[4]  = '{9,  4'b0000, 4'b1101, 4'h0, 1'b0};
      vecs[5]  = '{14, 4'b0000, 4'b1101, 4'h0, 1'b0};
      vecs[6]  = '{15, 4'b0000, 4'b1111, 4'h0, 1'b0};
      vecs[7]  = '{17, 4'b0000, 4'b1011, 4'h0, 1'b0};
      vecs[8]  = '{25, 4'b0000, 4'b0111, 4'h0, 1'b0};
      vecs[9]  = '{31, 4'b0000, 4'b1111, 4'h0, 1'b0};
      vecs[10] = '{32, 4'b0000, 4'b1111, 4'h0, 1'b1};
      vecs[11] = '{33, 4'b0100, 4'b1110, 4'h0, 1'b0};
      vecs[12] = '{41, 4'b0100, 4'b1101, 4'h0, 1'b0};
      vecs[13] = '{49, 4'b0100, 4'b1111, 4'h0, 1'b0};
      vecs[14] = '{52, 4'b0100, 4'b1111, 4'h0, 1'b0};
      vecs[15] = '{55, 4'b0100, 4'b1111, 4'h0, 1'b0};
      vecs[16] = '{57, 4'b0100, 4'b0111, 4'h0, 1'b0};
      vecs[17] = '{64, 4'b0100, 4'b1111, 4'h0, 1'b1};
      vecs[18] = '{65, 4'b0000, 4'b1110, 4'h0, 1'b0};
      vecs[19] = '{73, 4'b0000, 4'b1101, 4'h0, 1'b0};
      vecs[20] = '{81, 4'b0000, 4'b1011, 4'h0, 1'b0};

      rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
      commit_req = 1'b0; blank_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state();
      rst_n = 1'b1;
      cyc = 0;

      for (int i = 0; i < NV; i++) begin
         blank_mask = vecs[i].mask;
         goto_cyc(vecs[i].cyc);
         chk("tbl_an_n", 32'(an_n), 32'(vecs[i].an));
         chk("tbl_dec", 32'(dec_nibble), 32'(vecs[i].dec));
         chk("tbl_ftick", 32'(frame_tick), 32'(vecs[i].ft));
         chk("tbl_pend", 32'(commit_pend), 32'h0);
      end
      blank_mask = '0;

      // Commit of 1,2,3,4 requested mid-frame
      wr(2'd0, 4'h1); wr(2'd1, 4'h2); wr(2'd2, 4'h3); wr(2'd3, 4'h4);
      pulse_commit();
      chk("cA_pend_set", 32'(commit_pend), 32'h1);
      goto_cyc(95);
      chk("cA_pend_hold", 32'(commit_pend), 32'h1);
      chk("cA_done_early", 32'(commit_done), 32'h0);
      chk("cA_dec_old", 32'(dec_nibble), 32'h0);
      goto_cyc(96);
      chk("cA_done", 32'(commit_done), 32'h1);
      chk("cA_pend_clr", 32'(commit_pend), 32'h0);
      chk("cA_ftick", 32'(frame_tick), 32'h1);
      goto_cyc(97);
      chk("cA_done_1cyc", 32'(commit_done), 32'h0);
      chk("cA_dig0", 32'(dec_nibble), 32'h1);
      goto_cyc(103);
      chk("cA_blank_an", 32'(an_n), 32'hF);
      chk("cA_blank_hold", 32'(dec_nibble), 32'h1);
      goto_cyc(105); chk("cA_dig1", 32'(dec_nibble), 32'h2);
      goto_cyc(113); chk("cA_dig2", 32'(dec_nibble), 32'h3);
      goto_cyc(121); chk("cA_dig3", 32'(dec_nibble), 32'h4);
      chk("cA_an3", 32'(an_n), 32'b0111);

      // Shadow write without commit stays invisible
      wr(2'd2, 4'hA);
      goto_cyc(145); chk("cB_nocommit_f1", 32'(dec_nibble), 32'h3);
      goto_cyc(177); chk("cB_nocommit_f2", 32'(dec_nibble), 32'h3);
      goto_cyc(209); chk("cB_nocommit_f3", 32'(dec_nibble), 32'h3);
      pulse_commit();
      tick();
      pulse_commit();
      chk("cB_pend", 32'(commit_pend), 32'h1);
      goto_cyc(223);
      chk("cB_done_early", 32'(commit_done), 32'h0);
      goto_cyc(224);
      chk("cB_done", 32'(commit_done), 32'h1);
      goto_cyc(225);
      chk("cB_single_done", 32'(commit_done), 32'h0);
      chk("cB_pend_clr", 32'(commit_pend), 32'h0);
      chk("cB_dig0", 32'(dec_nibble), 32'h1);
      goto_cyc(241); chk("cB_dig2_A", 32'(dec_nibble), 32'hA);

      // Write and commit_req exactly in the frame-end cycle
      goto_cyc(255);
      wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'hF; commit_req = 1'b1;
      tick();
      wr_en = 1'b0; commit_req = 1'b0;
      chk("cC_done", 32'(commit_done), 32'h1);
      chk("cC_req_consumed", 32'(commit_pend), 32'h0);
      goto_cyc(257);
      chk("cC_dig0_old", 32'(dec_nibble), 32'h1);
      chk("cC_pend_after", 32'(commit_pend), 32'h0);
      goto_cyc(273); chk("cC_dig2", 32'(dec_nibble), 32'hA);
      goto_cyc(279);
      pulse_commit();
      goto_cyc(288); chk("cC_done2", 32'(commit_done), 32'h1);
      goto_cyc(289); chk("cC_dig0_F", 32'(dec_nibble), 32'hF);

      // Asynchronous reset mid-slot with a commit pending
      wr(2'd1, 4'h7);
      pulse_commit();
      goto_cyc(300);
      chk("cD_pend_before", 32'(commit_pend), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      goto_cyc(1);
      chk("cD_an_restart", 32'(an_n), 32'b1110);
      chk("cD_active0_clr", 32'(dec_nibble), 32'h0);
      pulse_commit();
      goto_cyc(32);
      chk("cD_done", 32'(commit_done), 32'h1);
      goto_cyc(41);
      chk("cD_shadow1_clr", 32'(dec_nibble), 32'h0);
      chk("cD_an1", 32'(an_n), 32'b1101);
      goto_cyc(57);
      chk("cD_active3_clr", 32'(dec_nibble), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
